// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter
// Shares one external pipelined multiply-add unit (result = A*B + C) among
// NUM_REQ requesters. A round-robin arbiter accepts at most one operation per
// cycle. C is issued on the accept edge. A and B follow C_LEAD edges later.
// A {valid, id} tag travels alongside the operation and meets mac_result
// C_LEAD+MAC_LAT edges after acceptance. The result is then reported on the
// shared result bus.
//
// Optional feature: define MAC_SHARE_STATS_EN to add per-requester 16-bit
// saturating grant counters (grant_count output, stats_clr input).
module mac_share_arbiter #(
    parameter int INPUT_WIDTH = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int NUM_REQ     = 4,
    parameter int C_LEAD      = 1,
    parameter int MAC_LAT     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_c,
    output logic [INPUT_WIDTH-1:0]         mac_a,
    output logic [INPUT_WIDTH-1:0]         mac_b,
    output logic [INPUT_WIDTH-1:0]         mac_c,
    input  logic [OUT_WIDTH-1:0]           mac_result,
    output logic                           res_valid,
    output logic [OUT_WIDTH-1:0]           res_data,
    output logic [$clog2(NUM_REQ)-1:0]     res_id,
    output logic                           busy
`ifdef MAC_SHARE_STATS_EN
    ,
    input  logic                           stats_clr,
    output logic [NUM_REQ*16-1:0]          grant_count
`endif
);

    localparam int IDW       = $clog2(NUM_REQ);
    localparam int TAG_DEPTH = C_LEAD + MAC_LAT;

    // Arbitration state and combinational grant decision
    logic [IDW-1:0]         ptr_r;
    logic [NUM_REQ-1:0]     ready_s;
    logic [IDW-1:0]         grant_id_s;
    logic                   accept_s;
    logic                   hit_s;
    int                     idx_s;

    // Operands of the accepted requester
    logic [INPUT_WIDTH-1:0] sel_a_s;
    logic [INPUT_WIDTH-1:0] sel_b_s;
    logic [INPUT_WIDTH-1:0] sel_c_s;

    // Tag pipeline: bit 0 is loaded on the accept edge, bit TAG_DEPTH-1
    // lines up with mac_result on the following edge.
    logic [TAG_DEPTH-1:0]   tag_v_r;
    logic [TAG_DEPTH-1:0]   tag_v_next_s;
    logic [IDW-1:0]         tag_id_r [TAG_DEPTH];

    // Round-robin search starting one slot after the last granted requester
    always_comb begin
        ready_s    = '0;
        grant_id_s = '0;
        accept_s   = 1'b0;
        hit_s      = 1'b0;
        idx_s      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx_s          = (int'(ptr_r) + off) % NUM_REQ;
            hit_s          = en & req_valid[idx_s] & ~accept_s;
            ready_s[idx_s] = ready_s[idx_s] | hit_s;
            grant_id_s     = hit_s ? IDW'(idx_s) : grant_id_s;
            accept_s       = accept_s | hit_s;
        end
    end

    assign req_ready = ready_s;

    assign sel_a_s = req_a[int'(grant_id_s)*INPUT_WIDTH +: INPUT_WIDTH];
    assign sel_b_s = req_b[int'(grant_id_s)*INPUT_WIDTH +: INPUT_WIDTH];
    assign sel_c_s = req_c[int'(grant_id_s)*INPUT_WIDTH +: INPUT_WIDTH];

    // The oldest tag leaves the pipe as the new one (if any) enters
    assign tag_v_next_s = (tag_v_r << 1) | TAG_DEPTH'(accept_s);

    // Round-robin pointer: remembers the last accepted requester
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= IDW'(NUM_REQ - 1);
        end else if (accept_s) begin
            ptr_r <= grant_id_s;
        end
    end

    // C slot: issued on the accept edge, zero on idle edges
    always_ff @(posedge clk) begin
        if (reset) begin
            mac_c <= '0;
        end else begin
            mac_c <= accept_s ? sel_c_s : '0;
        end
    end

    generate
        if (C_LEAD == 0) begin : g_ab_direct
            // A/B slots: issued on the same edge as C
            always_ff @(posedge clk) begin
                if (reset) begin
                    mac_a <= '0;
                    mac_b <= '0;
                end else begin
                    mac_a <= accept_s ? sel_a_s : '0;
                    mac_b <= accept_s ? sel_b_s : '0;
                end
            end
        end else begin : g_ab_delay
            logic [INPUT_WIDTH-1:0] a_dly_r [C_LEAD];
            logic [INPUT_WIDTH-1:0] b_dly_r [C_LEAD];

            // A/B delay line: each stage holds one edge's operands or zero
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < C_LEAD; k++) begin
                        a_dly_r[k] <= '0;
                        b_dly_r[k] <= '0;
                    end
                    mac_a <= '0;
                    mac_b <= '0;
                end else begin
                    a_dly_r[0] <= accept_s ? sel_a_s : '0;
                    b_dly_r[0] <= accept_s ? sel_b_s : '0;
                    for (int k = 1; k < C_LEAD; k++) begin
                        a_dly_r[k] <= a_dly_r[k-1];
                        b_dly_r[k] <= b_dly_r[k-1];
                    end
                    mac_a <= a_dly_r[C_LEAD-1];
                    mac_b <= b_dly_r[C_LEAD-1];
                end
            end
        end
    endgenerate

    // Tag pipeline, result capture and busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_r <= '0;
            for (int k = 0; k < TAG_DEPTH; k++) begin
                tag_id_r[k] <= '0;
            end
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            busy      <= 1'b0;
        end else begin
            tag_v_r     <= tag_v_next_s;
            tag_id_r[0] <= accept_s ? grant_id_s : '0;
            for (int k = 1; k < TAG_DEPTH; k++) begin
                tag_id_r[k] <= tag_id_r[k-1];
            end
            // Result fields only move when a tagged result arrives
            res_valid <= tag_v_r[TAG_DEPTH-1];
            if (tag_v_r[TAG_DEPTH-1]) begin
                res_data <= mac_result;
                res_id   <= tag_id_r[TAG_DEPTH-1];
            end
            // Busy drops on the same edge the last result is reported
            busy <= |tag_v_next_s;
        end
    end

`ifdef MAC_SHARE_STATS_EN
    logic [15:0] cnt_r [NUM_REQ];

    // Per-requester saturating grant counters; clear wins over increment
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt_r[k] <= 16'd0;
            end
        end else if (accept_s && (cnt_r[grant_id_s] != 16'hFFFF)) begin
            cnt_r[grant_id_s] <= cnt_r[grant_id_s] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_count[g*16 +: 16] = cnt_r[g];
    end
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed self-checking bench for mac_share_arbiter (default parameters).
// A small behavioural multiply-add unit supplies mac_result so that results
// for A*B+C are valid on the edge the arbiter samples them.
module tb_mac_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic [7:0]  mac_a, mac_b, mac_c;
    logic [15:0] mac_result;
    logic        res_valid;
    logic [15:0] res_data;
    logic [1:0]  res_id;
    logic        busy;
`ifdef MAC_SHARE_STATS_EN
    logic        stats_clr;
    logic [63:0] grant_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mac_share_arbiter dut (
        .clk(clk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_result(mac_result),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .busy(busy)
`ifdef MAC_SHARE_STATS_EN
        , .stats_clr(stats_clr), .grant_count(grant_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural multiply-add unit: C is held one edge to meet A/B, one
    // internal register, and the arbiter's capture edge completes MAC_LAT=2.
    logic [7:0]  c_hold;
    logic [15:0] prod_r;
    always @(posedge clk) begin
        c_hold <= mac_c;
        prod_r <= 16'(mac_a) * 16'(mac_b) + 16'(c_hold);
    end
    assign mac_result = prod_r;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_c[i*8 +: 8] = c;
    endtask

    task automatic test_reset;
        req_valid = 4'b0000; en = 1'b1; reset = 1'b1;
        req_a = 32'hAAAA_AAAA; req_b = 32'hAAAA_AAAA; req_c = 32'hAAAA_AAAA;
        tick; tick;
        reset = 1'b0;
        n_checks++; if (mac_a !== 8'd0) begin n_fail++; $display("FAIL reset_mac_a: got %0d expected 0", mac_a); end
        n_checks++; if (mac_b !== 8'd0) begin n_fail++; $display("FAIL reset_mac_b: got %0d expected 0", mac_b); end
        n_checks++; if (mac_c !== 8'd0) begin n_fail++; $display("FAIL reset_mac_c: got %0d expected 0", mac_c); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0b expected 0", res_valid); end
        n_checks++; if (res_data !== 16'd0) begin n_fail++; $display("FAIL reset_res_data: got %0d expected 0", res_data); end
        n_checks++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL reset_res_id: got %0d expected 0", res_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_idle: got %b expected 0000", req_ready); end
        req_valid = 4'b1111; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_priority: got %b expected 0001", req_ready); end
        req_valid = 4'b0000; #1;
    endtask

    task automatic test_single_op;
        set_ops(2, 8'd3, 8'd4, 8'd5);
        req_valid = 4'b0100; #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        tick; req_valid = 4'b0000;   // edge E
        n_checks++; if (mac_c !== 8'd5) begin n_fail++; $display("FAIL single_mac_c_E: got %0d expected 5", mac_c); end
        n_checks++; if (mac_a !== 8'd0) begin n_fail++; $display("FAIL single_mac_a_E: got %0d expected 0", mac_a); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_E: got %0b expected 1", busy); end
        tick;                        // E+1
        n_checks++; if (mac_a !== 8'd3) begin n_fail++; $display("FAIL single_mac_a_E1: got %0d expected 3", mac_a); end
        n_checks++; if (mac_b !== 8'd4) begin n_fail++; $display("FAIL single_mac_b_E1: got %0d expected 4", mac_b); end
        n_checks++; if (mac_c !== 8'd0) begin n_fail++; $display("FAIL single_mac_c_E1: got %0d expected 0", mac_c); end
        tick;                        // E+2
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_res_early: got %0b expected 0", res_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_E2: got %0b expected 1", busy); end
        tick;                        // E+3
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_res_valid: got %0b expected 1", res_valid); end
        n_checks++; if (res_data !== 16'd17) begin n_fail++; $display("FAIL single_res_data: got %0d expected 17", res_data); end
        n_checks++; if (res_id !== 2'd2) begin n_fail++; $display("FAIL single_res_id: got %0d expected 2", res_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %0b expected 0", busy); end
        tick;                        // E+4
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_res_one_cycle: got %0b expected 0", res_valid); end
        n_checks++; if (res_data !== 16'd17) begin n_fail++; $display("FAIL single_res_hold: got %0d expected 17", res_data); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [15:0] exp_data;
        reset = 1'b1; tick; reset = 1'b0;
        for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'(i + 2), 8'(i + 10));
        for (int t = 0; t < 11; t++) begin
            req_valid = (t < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_ready = (t < 8) ? (4'b0001 << (t % 4)) : 4'b0000;
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", t, req_ready, exp_ready); end
            tick;
            if (t >= 3) begin
                exp_id   = 2'((t - 3) % 4);
                exp_data = 16'((exp_id + 1) * (exp_id + 2) + exp_id + 10);
                n_checks++; if (res_valid !== 1'b1 || res_id !== exp_id || res_data !== exp_data) begin n_fail++; $display("FAIL rr_result[%0d]: got v=%0b id=%0d data=%0d expected v=1 id=%0d data=%0d", t, res_valid, res_id, res_data, exp_id, exp_data); end
            end else begin
                n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rr_no_result[%0d]: got %0b expected 0", t, res_valid); end
            end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_done: got %0b expected 0", busy); end
    endtask

    task automatic test_skip_wrap;
        reset = 1'b1; tick; reset = 1'b0;
        set_ops(0, 8'd2, 8'd2, 8'd1);
        set_ops(1, 8'd1, 8'd1, 8'd1);
        set_ops(3, 8'd5, 8'd5, 8'd0);
        req_valid = 4'b0010; #1;     // move pointer to 1
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_setup_ready: got %b expected 0010", req_ready); end
        tick; req_valid = 4'b0000;
        tick; tick; tick;
        req_valid = 4'b1001; #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_first_grant: got %b expected 1000", req_ready); end
        n_checks++; if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL skip_onehot_a: got %b expected at most one bit", req_ready); end
        tick; req_valid = 4'b0001; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_wrap_grant: got %b expected 0001", req_ready); end
        n_checks++; if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL skip_onehot_b: got %b expected at most one bit", req_ready); end
        tick; req_valid = 4'b0000;
        tick; tick;
        n_checks++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_data !== 16'd25) begin n_fail++; $display("FAIL skip_res_first: got v=%0b id=%0d data=%0d expected v=1 id=3 data=25", res_valid, res_id, res_data); end
        tick;
        n_checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'd5) begin n_fail++; $display("FAIL skip_res_second: got v=%0b id=%0d data=%0d expected v=1 id=0 data=5", res_valid, res_id, res_data); end
        tick;
    endtask

    task automatic test_en_gating;
        set_ops(1, 8'd7, 8'd6, 8'd9);
        en = 1'b0; req_valid = 4'b0010; #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_blocked_ready: got %b expected 0000", req_ready); end
        tick; tick;
        n_checks++; if (mac_c !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL en_no_issue: got mac_c=%0d busy=%0b expected 0 0", mac_c, busy); end
        en = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL en_ready_after: got %b expected 0010", req_ready); end
        tick;                        // accepted
        n_checks++; if (mac_c !== 8'd9 || busy !== 1'b1) begin n_fail++; $display("FAIL en_issue: got mac_c=%0d busy=%0b expected 9 1", mac_c, busy); end
        en = 1'b0; #1;               // requester 1 still valid, en drops mid-flight
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_drop_ready: got %b expected 0000", req_ready); end
        tick; tick;
        n_checks++; if (mac_c !== 8'd0) begin n_fail++; $display("FAIL en_drop_no_issue: got %0d expected 0", mac_c); end
        tick;
        n_checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 16'd51) begin n_fail++; $display("FAIL en_drain_result: got v=%0b id=%0d data=%0d expected v=1 id=1 data=51", res_valid, res_id, res_data); end
        req_valid = 4'b0000; en = 1'b1;
        tick;
    endtask

    task automatic test_reset_midflight;
        set_ops(0, 8'd9, 8'd9, 8'd9);
        set_ops(1, 8'd8, 8'd8, 8'd8);
        req_valid = 4'b0011; #1;
        tick; tick;
        req_valid = 4'b0000;
        reset = 1'b1; tick; reset = 1'b0;
        n_checks++; if (mac_a !== 8'd0 || mac_b !== 8'd0 || mac_c !== 8'd0) begin n_fail++; $display("FAIL midrst_operands: got a=%0d b=%0d c=%0d expected 0 0 0", mac_a, mac_b, mac_c); end
        n_checks++; if (res_valid !== 1'b0 || res_data !== 16'd0 || res_id !== 2'd0) begin n_fail++; $display("FAIL midrst_result: got v=%0b data=%0d id=%0d expected 0 0 0", res_valid, res_data, res_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        for (int t = 0; t < 5; t++) begin
            tick;
            n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost[%0d]: got %0b expected 0", t, res_valid); end
        end
        req_valid = 4'b1111; #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_next_grant: got %b expected 0001", req_ready); end
        tick; req_valid = 4'b0000;
        tick; tick; tick;
    endtask

`ifdef MAC_SHARE_STATS_EN
    task automatic test_stats;
        stats_clr = 1'b0;
        reset = 1'b1; tick; reset = 1'b0;
        set_ops(1, 8'd1, 8'd1, 8'd1);
        req_valid = 4'b0010;
        for (int t = 0; t < 5; t++) tick;
        req_valid = 4'b0000; #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (grant_count[i*16 +: 16] !== ((i == 1) ? 16'd5 : 16'd0)) begin n_fail++; $display("FAIL stats_count[%0d]: got %0d expected %0d", i, grant_count[i*16 +: 16], (i == 1) ? 5 : 0); end
        end
        req_valid = 4'b0010; stats_clr = 1'b1;
        tick;
        stats_clr = 1'b0; req_valid = 4'b0000;
        n_checks++; if (grant_count !== 64'd0) begin n_fail++; $display("FAIL stats_clr_wins: got %h expected 0", grant_count); end
        tick; tick; tick;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef MAC_SHARE_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset;
        test_single_op;
        test_round_robin;
        test_skip_wrap;
        test_en_gating;
        test_reset_midflight;
`ifdef MAC_SHARE_STATS_EN
        test_stats;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
